// File: rtl/mmu_addresses_pkg.sv
// CPU-visible register addresses and the DMA source-page address folding rule.
package mmu_addresses_pkg;

  localparam logic [15:0] DMA_OAM_addr = 16'hFF46;

  // Pages E0..FF mirror work RAM at C0..DF, so the DMA engine reads from the mirror origin.
  function automatic logic [7:0] dma_src_page(input logic [7:0] page);
    logic [7:0] folded;
    if (page >= 8'hE0) begin
      folded = page - 8'h20;
    end else begin
      folded = page;
    end
    return folded;
  endfunction

endpackage

// File: rtl/ppu_types_pkg.sv
// PPU-wide types and constants shared by the PPU and OAM DMA engine.
package ppu_types_pkg;

  localparam int OAM_len       = 160;
  localparam int DMA_START_LEN = 4;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU register bus, source read port and OAM write port of the OAM DMA engine.
interface oam_dma_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_write_en;
  logic        bus_read_en;
  logic [7:0]  bus_rdata;
  logic [15:0] src_addr;
  logic        src_read_req;
  logic [7:0]  src_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_active;

  modport slave (
    input  bus_addr, bus_wdata, bus_write_en, bus_read_en, src_rdata,
    output bus_rdata, src_addr, src_read_req, oam_addr, oam_wdata, oam_we, dma_active
  );

  modport master (
    output bus_addr, bus_wdata, bus_write_en, bus_read_en, src_rdata,
    input  bus_rdata, src_addr, src_read_req, oam_addr, oam_wdata, oam_we, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from {page, 00..9F} into OAM,
// one byte per M-cycle after a 4-clock start-up delay.
module oam_dma
  import ppu_types_pkg::*;
  import mmu_addresses_pkg::*;
(
  input logic        clk,
  input logic        reset,
  oam_dma_if.slave   bus
);

  localparam logic [7:0] LAST_IDX   = 8'(OAM_len - 1);
  localparam logic [1:0] START_LAST = 2'(DMA_START_LEN - 1);

  dma_state_t  state_r;
  logic [7:0]  page_r;
  logic [7:0]  byte_idx_r;
  logic [1:0]  phase_r;
  logic [7:0]  data_r;
  logic [15:0] src_addr_r;
  logic        src_read_req_r;
  logic [7:0]  oam_addr_r;
  logic        oam_we_r;
  logic        dma_active_r;
  logic        dma_write_s;

  assign dma_write_s = bus.bus_write_en && (bus.bus_addr == DMA_OAM_addr);

  assign bus.bus_rdata    = (bus.bus_read_en && (bus.bus_addr == DMA_OAM_addr)) ? page_r : 8'hFF;
  assign bus.src_addr     = src_addr_r;
  assign bus.src_read_req = src_read_req_r;
  assign bus.oam_addr     = oam_addr_r;
  assign bus.oam_wdata    = data_r;
  assign bus.dma_active   = dma_active_r;
  // Reset must suppress an OAM write already scheduled for the clock in which it rises.
  assign bus.oam_we       = oam_we_r && !reset;

  // Transfer sequencer: strobes are one clock wide, so they default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= DMA_IDLE;
      page_r         <= 8'h00;
      byte_idx_r     <= 8'h00;
      phase_r        <= 2'd0;
      data_r         <= 8'h00;
      src_addr_r     <= 16'h0000;
      src_read_req_r <= 1'b0;
      oam_addr_r     <= 8'h00;
      oam_we_r       <= 1'b0;
      dma_active_r   <= 1'b0;
    end else begin
      src_read_req_r <= 1'b0;
      oam_we_r       <= 1'b0;
      if (dma_write_s) begin
        // A new page write restarts from any state; an in-flight write completes on its own.
        page_r       <= bus.bus_wdata;
        state_r      <= DMA_START;
        phase_r      <= 2'd0;
        byte_idx_r   <= 8'h00;
        dma_active_r <= 1'b1;
      end else begin
        case (state_r)
          DMA_IDLE: begin
            dma_active_r <= 1'b0;
          end
          DMA_START: begin
            if (phase_r == START_LAST) begin
              state_r <= DMA_XFER;
              phase_r <= 2'd0;
            end else begin
              phase_r <= phase_r + 2'd1;
            end
          end
          DMA_XFER: begin
            phase_r <= phase_r + 2'd1;
            case (phase_r)
              2'd1: begin
                src_read_req_r <= 1'b1;
                src_addr_r     <= {dma_src_page(page_r), byte_idx_r};
              end
              2'd2: begin
                data_r     <= bus.src_rdata;
                oam_we_r   <= 1'b1;
                oam_addr_r <= byte_idx_r;
              end
              2'd3: begin
                if (byte_idx_r == LAST_IDX) begin
                  state_r      <= DMA_IDLE;
                  byte_idx_r   <= 8'h00;
                  dma_active_r <= 1'b0;
                end else begin
                  byte_idx_r <= byte_idx_r + 8'd1;
                end
              end
              default: begin
              end
            endcase
          end
          default: begin
            state_r      <= DMA_IDLE;
            dma_active_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: full transfers, page folding, restarts, register reads and reset abort.
module tb_oam_dma;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [7:0] oam_mem [0:255];

  oam_dma_if bus ();

  oam_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory image: byte i of page p holds i ^ 5A ^ (p - C1), so page C1 gives i ^ 5A.
  assign bus.src_rdata = bus.src_read_req ?
                         (bus.src_addr[7:0] ^ 8'h5A ^ (bus.src_addr[15:8] - 8'hC1)) : 8'h00;

  // OAM image built from the observed write port.
  always @(negedge clk) begin
    if (bus.oam_we) begin
      oam_mem[bus.oam_addr] = bus.oam_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input int k, input logic [7:0] sp);
    return 8'(k) ^ 8'h5A ^ (sp - 8'hC1);
  endfunction

  // Drive a CPU write; returns #1 after the edge that samples it.
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    bus.bus_addr     = addr;
    bus.bus_wdata    = data;
    bus.bus_write_en = 1'b1;
    @(posedge clk);
    #1;
    bus.bus_write_en = 1'b0;
    bus.bus_addr     = 16'h0000;
    bus.bus_wdata    = 8'h00;
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr, input logic en,
                            input logic [7:0] exp);
    bus.bus_addr    = addr;
    bus.bus_read_en = en;
    #1;
    check_eq(tag, 32'(bus.bus_rdata), 32'(exp));
    bus.bus_read_en = 1'b0;
    bus.bus_addr    = 16'h0000;
  endtask

  // Check every output in cycle c of an uninterrupted transfer whose source page is sp.
  task automatic cycle_check(input int c, input logic [7:0] sp);
    logic exp_act;
    logic exp_rd;
    logic exp_we;
    int   k;
    @(negedge clk);
    exp_act = (c >= 1) && (c <= 644);
    exp_rd  = (c >= 7) && (c <= 643) && (((c - 7) % 4) == 0);
    exp_we  = (c >= 8) && (c <= 644) && (((c - 8) % 4) == 0);
    check_eq($sformatf("dma_active c%0d", c), 32'(bus.dma_active), 32'(exp_act));
    check_eq($sformatf("src_read_req c%0d", c), 32'(bus.src_read_req), 32'(exp_rd));
    check_eq($sformatf("oam_we c%0d", c), 32'(bus.oam_we), 32'(exp_we));
    if (exp_rd) begin
      k = (c - 7) / 4;
      check_eq($sformatf("src_addr c%0d", c), 32'(bus.src_addr), 32'({sp, 8'(k)}));
    end
    if (exp_we) begin
      k = (c - 8) / 4;
      check_eq($sformatf("oam_addr c%0d", c), 32'(bus.oam_addr), 32'(k));
      check_eq($sformatf("oam_wdata c%0d", c), 32'(bus.oam_wdata), 32'(src_byte(k, sp)));
    end
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    reset            = 1'b1;
    bus.bus_addr     = 16'h0000;
    bus.bus_wdata    = 8'h00;
    bus.bus_write_en = 1'b0;
    bus.bus_read_en  = 1'b0;
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst dma_active", 32'(bus.dma_active), 32'h0);
    check_eq("rst src_read_req", 32'(bus.src_read_req), 32'h0);
    check_eq("rst oam_we", 32'(bus.oam_we), 32'h0);
    check_eq("rst oam_addr", 32'(bus.oam_addr), 32'h0);
    check_eq("rst oam_wdata", 32'(bus.oam_wdata), 32'h0);
    check_eq("rst src_addr", 32'(bus.src_addr), 32'h0);
    read_check("rst page read", 16'hFF46, 1'b1, 8'h00);
    reset = 1'b0;

    // Full transfer from page C1.
    @(negedge clk);
    bus_write(16'hFF46, 8'hC1);
    for (int c = 1; c <= 648; c++) cycle_check(c, 8'hC1);
    for (int k = 0; k < 160; k++)
      check_eq($sformatf("oam C1 [%0d]", k), 32'(oam_mem[k]), 32'(8'(k) ^ 8'h5A));

    // Writes elsewhere are ignored.
    bus_write(16'hFF45, 8'h33);
    @(negedge clk);
    check_eq("ignored write active", 32'(bus.dma_active), 32'h0);
    read_check("page after FF45 write", 16'hFF46, 1'b1, 8'hC1);

    // Folded page F2 reads D200..D29F.
    bus_write(16'hFF46, 8'hF2);
    for (int c = 1; c <= 648; c++) cycle_check(c, 8'hD2);

    // Fold boundary E0 -> C0; restart coincident with the byte-10 write at cycle 48.
    bus_write(16'hFF46, 8'hE0);
    for (int c = 1; c <= 48; c++) cycle_check(c, 8'hC0);
    bus_write(16'hFF46, 8'hDF);
    // Unfolded boundary DF; restart in the byte-6 read cycle (31) must drop that byte.
    for (int c = 1; c <= 31; c++) cycle_check(c, 8'hDF);
    check_eq("oam[10] kept on restart", 32'(oam_mem[10]), 32'(8'd10 ^ 8'h5A ^ 8'hFF));
    check_eq("oam[6] before DF write", 32'(oam_mem[6]), 32'(8'd6 ^ 8'h5A ^ 8'hFF));
    bus_write(16'hFF46, 8'hC0);

    // Page C0 restarted by D0 at cycle 100.
    for (int c = 1; c <= 100; c++) cycle_check(c, 8'hC0);
    check_eq("oam[6] dropped byte", 32'(oam_mem[6]), 32'(8'd6 ^ 8'h5A ^ 8'hFF));
    for (int k = 0; k <= 22; k++)
      check_eq($sformatf("oam C0 [%0d]", k), 32'(oam_mem[k]), 32'(8'(k) ^ 8'h5A ^ 8'hFF));
    read_check("read FF46", 16'hFF46, 1'b1, 8'hC0);
    read_check("read FF45", 16'hFF45, 1'b1, 8'hFF);
    read_check("read FF46 no en", 16'hFF46, 1'b0, 8'hFF);
    bus_write(16'hFF46, 8'hD0);
    for (int c = 1; c <= 648; c++) cycle_check(c, 8'hD0);
    for (int k = 0; k < 160; k++)
      check_eq($sformatf("oam D0 [%0d]", k), 32'(oam_mem[k]), 32'(8'(k) ^ 8'h5A ^ 8'h0F));

    // Reset at cycle 300 (byte-73 write cycle) aborts the transfer.
    bus_write(16'hFF46, 8'hC1);
    for (int c = 1; c <= 299; c++) cycle_check(c, 8'hC1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("oam_we during reset", 32'(bus.oam_we), 32'h0);
    check_eq("src_read_req during reset", 32'(bus.src_read_req), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset dma_active", 32'(bus.dma_active), 32'h0);
    check_eq("reset oam_addr", 32'(bus.oam_addr), 32'h0);
    check_eq("reset src_addr", 32'(bus.src_addr), 32'h0);
    read_check("reset page read", 16'hFF46, 1'b1, 8'h00);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check_eq($sformatf("post-reset oam_we %0d", c), 32'(bus.oam_we), 32'h0);
      check_eq($sformatf("post-reset active %0d", c), 32'(bus.dma_active), 32'h0);
    end
    for (int k = 0; k <= 72; k++)
      check_eq($sformatf("oam pre-reset [%0d]", k), 32'(oam_mem[k]), 32'(8'(k) ^ 8'h5A));
    for (int k = 73; k < 160; k++)
      check_eq($sformatf("oam untouched [%0d]", k), 32'(oam_mem[k]), 32'(8'(k) ^ 8'h5A ^ 8'h0F));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 clk  input  1  single dot clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 bus_addr  input  16  CPU-side address.
REQ-004 bus_wdata  input  8  CPU write data.
REQ-005 bus_write_en  input  1  CPU write strobe; acts only when bus_addr = 16'hFF46 (DMA_OAM_addr).
REQ-006 bus_read_en  input  1  CPU read strobe.
REQ-007 bus_rdata  output  8  page register when reading FF46, otherwise 8'hFF; combinational.
REQ-008 src_addr  output  16  source byte address {src_page, byte_idx}.
REQ-009 src_read_req  output  1  one-clk source read request.
REQ-010 src_rdata  input  8  source data, valid combinationally in the same clk as src_read_req.
REQ-011 oam_addr  output  8  OAM byte index, 0..159.
REQ-012 oam_wdata  output  8  byte to write into OAM.
REQ-013 oam_we  output  1  one-clk OAM write strobe.
REQ-014 dma_active  output  1  high while in START or XFER; used by the bus arbiter and PPU to block CPU/OAM access.

Function
REQ-015 States: IDLE, START, XFER; dma_active = (state != IDLE), registered.
REQ-016 A FF46 write in cycle 0 latches page_reg <= bus_wdata and enters START at cycle 1, from any state.
REQ-017 START lasts exactly 4 clks (cycles 1-4), then enters XFER with byte_idx = 0 and phase = 0.
REQ-018 XFER uses a 2-bit phase counter; each byte takes 4 clks (one M-cycle).
REQ-019 Phase 2 of byte k: src_read_req = 1, src_addr = {src_page, byte_idx}, src_rdata captured into data_reg.
REQ-020 Phase 3 of byte k: oam_we = 1, oam_addr = k, oam_wdata = data_reg.
REQ-021 Byte k read occurs in cycle 7+4k; byte k write occurs in cycle 8+4k.
REQ-022 After the byte-159 write (cycle 644), the block returns to IDLE; dma_active is low from cycle 645.
REQ-023 Source page folding: page_reg in 8'hE0..8'hFF gives src_page = page_reg - 8'h20; otherwise src_page = page_reg.
REQ-024 src_addr low byte = byte_idx (8-bit); byte_idx never exceeds 159 and never wraps.
REQ-025 Restart: a FF46 write during START or XFER aborts the current transfer and re-enters START with the new page.
REQ-026 On restart, a byte whose phase-3 write has not yet occurred is not written.
REQ-027 A FF46 write in the same clk as a phase-3 write lets that write complete, then START begins next clk.
REQ-028 src_read_req and oam_we are never high in the same clk and are 0 outside XFER.
REQ-029 bus_rdata = page_reg when bus_read_en and bus_addr = FF46, independent of state.
REQ-030 Writes to any address other than FF46 are ignored.

Reset
REQ-031 Reset forces: state = IDLE; page_reg = 8'h00; byte_idx = 0; phase = 0; data_reg = 8'h00.
REQ-032 Reset forces outputs: dma_active = 0, src_read_req = 0, oam_we = 0, oam_addr = 0, oam_wdata = 0, src_addr = 16'h0000.
REQ-033 Reset asserted mid-transfer aborts immediately; no oam_we occurs in any clk where reset is high or after it, until a new FF46 write.
REQ-034 Reset has priority over a simultaneous FF46 write.

Structure
REQ-035 Existing packages are reused: DMA_OAM_addr from mmu_addresses_pkg; OAM_len from ppu_types_pkg.
REQ-036 The dma_state_t enum and DMA_START_LEN = 4 are added to ppu_types_pkg.
REQ-037 Single flat module with no sub-modules; the PPU OAM write port muxes oam_we/oam_addr/oam_wdata ahead of CPU writes.

Verification
REQ-038 Scenario: write FF46 = 8'hC1 with source memory[C100+i] = i ^ 8'h5A -> 160 oam_we pulses at cycles 8+4k with oam_wdata = k ^ 8'h5A; dma_active is high for cycles 1-644.
REQ-039 Scenario: write 8'hF2 -> src_addr runs D200..D29F.
REQ-040 Scenario: after FF46 = 8'hC0, read FF46 -> 8'hC0; reads of other addresses -> 8'hFF.
REQ-041 Scenario: write 8'hC0, then write 8'hD0 at cycle 100 -> OAM[0..22] hold C0xx data; next write to OAM[0] is D000 data at cycle 100+8; dma_active drops at cycle 100+644+1.
REQ-042 Scenario: assert reset at cycle 300 -> dma_active = 0 and no further oam_we; OAM[74..159] unchanged.
REQ-043 Scenario: FF46 write coincident with the byte-10 write -> OAM[10] is written, then START occurs.
